fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage. Holds the PC and a synchronous-read instruction memory, with a loader write port.
- Fetched words pass through a small prefetch FIFO to decode, with valid/ready backpressure.
- Branch redirect flushes queued and in-flight fetches.
- Successor to the single-cycle fetch: adds reset, handshake, buffering, configurable width, depth and PC step, and an out-of-range fault flag.

Parameters:
- DATA_W, 32, instruction width.
- ADDR_W, 32, PC width.
- IMEM_DEPTH, 32, instruction memory entries. Must be ≥2.
- PC_STEP, 1, PC increment per instruction: 1 = word addressing, 4 = byte addressing. Must be a power of two.
- RESET_PC, 0, PC value after reset.
- BUF_DEPTH, 2, prefetch FIFO entries. Must be ≥2.

Ports:
- clk, in, 1, clock; all state changes on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- fetch_en, in, 1, permits new fetch issue.
- redirect_valid, in, 1, branch/jump taken this cycle.
- redirect_pc, in, ADDR_W, target PC.
- imem_we, in, 1, loader write enable.
- imem_waddr, in, clog2(IMEM_DEPTH), loader word index.
- imem_wdata, in, DATA_W, loader data.
- out_valid, out, 1, head instruction valid.
- out_ready, in, 1, decode accepts the head.
- out_instr, out, DATA_W, instruction.
- out_pc, out, ADDR_W, PC of out_instr.
- out_pc_next, out, ADDR_W, out_pc + PC_STEP.
- out_fault, out, 1, PC was outside the memory; out_instr forced to 0.

Behaviour:
- Reset (async, any time):
  - pc = RESET_PC; FIFO empty; in-flight flag cleared.
  - out_valid = 0, out_instr = 0, out_pc = 0, out_pc_next = 0, out_fault = 0.
  - Memory contents are not reset.
- Index and fault:
  - idx = pc / PC_STEP (shift).
  - Fault when idx ≥ IMEM_DEPTH, or when pc is not a multiple of PC_STEP.
- pop = out_valid & out_ready.
- Issue condition: issue = fetch_en & !redirect_valid & (count + inflight − pop < BUF_DEPTH).
  - out_ready feeds issue combinationally.
  - Steady-state throughput is 1 instruction/cycle with BUF_DEPTH ≥ 2.
- On issue:
  - Registered memory read of imem[idx].
  - inflight <= 1; tag <= {pc, fault}.
  - pc <= pc + PC_STEP, modulo 2^ADDR_W; wraps silently.
- Latency: the word issued in cycle N is written to the FIFO at the end of cycle N+1. The earliest out_valid is cycle N+2 after issue.
  - First valid after reset with fetch_en = 1 and no redirect is the 2nd rising edge after rst_n deasserts.
- Memory write:
  - Synchronous, takes effect at the edge.
  - Same-cycle write and read to the same index returns the OLD data (read-first).
  - Writes are independent of fetch state.
- FIFO:
  - Circular buffer, wrap-around pointers, count 0..BUF_DEPTH.
  - Head drives the outputs; out_valid = (count != 0).
  - Push and pop in the same cycle leave count unchanged.
  - Output values are held stable while out_valid & !out_ready.
- Redirect (highest priority):
  - pc <= redirect_pc; FIFO cleared (count = 0).
  - Any in-flight read is discarded and not pushed.
  - No issue that cycle; out_valid = 0 from the next cycle.
  - The first fetch from redirect_pc issues the following cycle.
  - An out_ready pop in the redirect cycle is still a legal accept of the old head.
- Back-to-back redirects: the last one wins. Each redirect discards everything older.
- fetch_en low: no new issue. An in-flight read still completes into the FIFO; pc holds.
- A full FIFO with out_ready low stalls issue; pc holds. No entry is lost or duplicated.
- Faulted fetch: pushes out_instr = 0 and out_fault = 1, and fetching continues. Decode is responsible for trapping.

Test Plan:
- Load imem[i] = 0xA000_0000 + i for i = 0..7; release reset; fetch_en = 1, out_ready = 1 → out_valid from the 2nd edge. Then out_pc 0,1,2,... on consecutive cycles with out_instr = 0xA000_0000 + out_pc and out_pc_next = out_pc + 1.
- Hold out_ready = 0 for 5 cycles, then 1 → FIFO fills to BUF_DEPTH and pc stops. Outputs are stable during the hold; the sequence resumes with no gap, duplicate or skip.
- Assert redirect_valid with redirect_pc = 5 while the FIFO is full and a read is in flight → out_valid = 0 the next cycle. The next valid has out_pc = 5 and out_instr = 0xA000_0005; no stale entries appear.
- PC_STEP = 4, IMEM_DEPTH = 8: redirect to 28 → instr idx 7 with fault 0. Then pc 32 → out_fault = 1 and out_instr = 0. Redirect to 6 → out_fault = 1 (misaligned).
- In the same cycle, write imem[3] = 0xDEAD_BEEF and fetch pc = 3 → old word returned. Redirect to 3 → 0xDEAD_BEEF returned.
- Pulse rst_n low mid-stream with the FIFO non-empty → outputs zero immediately (asynchronous). After release, fetch restarts at RESET_PC and memory contents are retained.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, synchronous-read instruction memory with a loader port,
// and a small prefetch FIFO toward decode with valid/ready handshake and redirect flush.
module fetch_unit #(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        IMEM_DEPTH = 32,
  parameter int unsigned        PC_STEP    = 1,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter int unsigned        BUF_DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fetch_en,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_pc,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [DATA_W-1:0]             imem_wdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_instr,
  output logic [ADDR_W-1:0]             out_pc,
  output logic [ADDR_W-1:0]             out_pc_next,
  output logic                          out_fault
);

  localparam int unsigned IW    = $clog2(IMEM_DEPTH);
  localparam int unsigned Shift = $clog2(PC_STEP);
  localparam int unsigned PW    = $clog2(BUF_DEPTH);
  localparam int unsigned CW    = $clog2(BUF_DEPTH + 1);

  localparam logic [ADDR_W-1:0] StepMask = ADDR_W'(PC_STEP - 1);
  localparam logic [ADDR_W-1:0] Step     = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] Depth    = ADDR_W'(IMEM_DEPTH);

  // Fetch-side state
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] tag_pc_q;
  logic              tag_fault_q;
  logic [DATA_W-1:0] rdata_q;

  // FIFO state
  logic [DATA_W-1:0] fifo_instr [BUF_DEPTH];
  logic [ADDR_W-1:0] fifo_pc    [BUF_DEPTH];
  logic              fifo_fault [BUF_DEPTH];
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [DATA_W-1:0] mem [IMEM_DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [IW-1:0]     ridx;
  logic              misaligned;
  logic              out_of_range;
  logic              fetch_fault;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CW:0]       occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign idx          = pc_q >> Shift;
  assign ridx         = idx[IW-1:0];
  assign misaligned   = |(pc_q & StepMask);
  assign out_of_range = (idx >= Depth);
  assign fetch_fault  = out_of_range | misaligned;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A redirect kills whatever read is returning this cycle.
  assign push      = inflight_q & ~redirect_valid;

  // Slots already committed (stored + returning) minus the one leaving this cycle.
  assign occupancy = (CW + 1)'(count_q) + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
  assign issue     = fetch_en & ~redirect_valid & (occupancy < (CW + 1)'(BUF_DEPTH));

  always_comb begin
    pc_d       = pc_q;
    inflight_d = issue;
    count_d    = count_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
    end else begin
      if (issue) begin
        pc_d = pc_q + Step;
      end
      if (push) begin
        wptr_d = ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      inflight_q  <= 1'b0;
      tag_pc_q    <= '0;
      tag_fault_q <= 1'b0;
      count_q     <= '0;
      rptr_q      <= '0;
      wptr_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      if (issue) begin
        tag_pc_q    <= pc_q;
        tag_fault_q <= fetch_fault;
      end
    end
  end

  // Memory is not reset; read-first falls out of non-blocking ordering.
  always_ff @(posedge clk) begin
    if (issue && !fetch_fault) begin
      rdata_q <= mem[ridx];
    end
    if (imem_we && (32'(imem_waddr) < IMEM_DEPTH)) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wptr_q] <= tag_fault_q ? '0 : rdata_q;
      fifo_pc[wptr_q]    <= tag_pc_q;
      fifo_fault[wptr_q] <= tag_fault_q;
    end
  end

  // Stale payload is masked so an empty FIFO presents all-zero outputs.
  always_comb begin
    out_instr   = '0;
    out_pc      = '0;
    out_pc_next = '0;
    out_fault   = 1'b0;
    if (out_valid) begin
      out_instr   = fifo_instr[rptr_q];
      out_pc      = fifo_pc[rptr_q];
      out_pc_next = fifo_pc[rptr_q] + Step;
      out_fault   = fifo_fault[rptr_q];
    end
  end

endmodule
